dmr_recovery_ctrl: RTL and testbench

Sequencing controller for the dual-modular-redundant lockstep pair. Watches the DMR comparator mismatch flag, halts both harts through their debug requests, triggers a resynchronisation restart, and counts retries. Declares a sticky permanent fault when retries are exhausted or a hart fails to halt. Sits between the DMR comparator, the two cores' debug/restart inputs and the platform interrupt/status logic.

---
 rtl/eros_pkg.sv | 16 +
 rtl/dmr_recovery_ctrl_if.sv | 42 ++++
 rtl/dmr_sat_counter.sv | 40 ++++
 rtl/dmr_recovery_ctrl.sv | 142 ++++++++++++++
 tb/tb_dmr_recovery_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eros_pkg.sv
// Shared types and constants for the lockstep recovery controller.
//   dmr_rec_state_e : recovery FSM state encoding (3-bit)
//   DMR_RETRY_W     : width of the retry counter / retry_cnt_o
package eros_pkg;

  localparam int unsigned DMR_RETRY_W = 4;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    LOCKSTEP = 3'd1,
    HALT     = 3'd2,
    RESYNC   = 3'd3,
    FAULT    = 3'd4
  } dmr_rec_state_e;

endpackage

// File: rtl/dmr_recovery_ctrl_if.sv
// Signal bundle between the recovery controller and its surroundings
// (DMR comparator, the two cores' debug/restart inputs, platform status).
//   slave  : controller view (samples enable/error/halted/resync_done/clear,
//            drives debug_req/resync/bus_gate/error_irq/fault/retry_cnt/state)
//   master : environment view (the reverse directions)
//
// Signalling: there is no valid/ready pair here. enable_i and halted_i are
// levels; resync_done_i and clear_i are single-cycle pulses sampled on the
// rising clock edge; resync_o and error_irq_o are single-cycle pulses; all
// other outputs are levels. state_o exposes the FSM state for observation.
interface dmr_recovery_ctrl_if
  import eros_pkg::*;
#(
  parameter int unsigned NHARTS = 2
);

  logic                   enable_i;
  logic                   error_i;
  logic [NHARTS-1:0]      halted_i;
  logic                   resync_done_i;
  logic                   clear_i;
  logic [NHARTS-1:0]      debug_req_o;
  logic                   resync_o;
  logic                   bus_gate_o;
  logic                   error_irq_o;
  logic                   fault_o;
  logic [DMR_RETRY_W-1:0] retry_cnt_o;
  dmr_rec_state_e         state_o;

  modport slave (
    input  enable_i, error_i, halted_i, resync_done_i, clear_i,
    output debug_req_o, resync_o, bus_gate_o, error_irq_o, fault_o,
           retry_cnt_o, state_o
  );

  modport master (
    output enable_i, error_i, halted_i, resync_done_i, clear_i,
    input  debug_req_o, resync_o, bus_gate_o, error_irq_o, fault_o,
           retry_cnt_o, state_o
  );

endinterface

// File: rtl/dmr_sat_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : return to zero (wins over en_i)
//   en_i          : count up by one, holding at MAX
//   tc_o          : count currently equals MAX
module dmr_sat_counter #(
  parameter int unsigned MAX = 255,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmr_recovery_ctrl.sv
// Recovery sequencer for a dual-modular-redundant lockstep pair.
// On a comparator mismatch it halts both harts via debug request, fires a
// resynchronisation restart, and counts retries; too many retries or a halt
// timeout park the pair in a sticky FAULT until software clears it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   dmr (slave)   : enable/error/halted/resync_done/clear in;
//                   debug_req/resync/bus_gate/error_irq/fault/retry_cnt/state out
// Every output comes straight from a flop.
module dmr_recovery_ctrl
  import eros_pkg::*;
#(
  parameter int unsigned NHARTS       = 2,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned HALT_TIMEOUT = 255,
  parameter int unsigned CLEAN_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dmr_recovery_ctrl_if.slave dmr
);

  localparam int unsigned CLEAN_W = $clog2(CLEAN_CYCLES + 1);
  localparam int unsigned TOUT_W  = $clog2(HALT_TIMEOUT + 1);
  localparam logic [DMR_RETRY_W-1:0] MAX_RETRY_V = DMR_RETRY_W'(MAX_RETRIES);

  dmr_rec_state_e         state_d, state_q;
  logic [DMR_RETRY_W-1:0] retry_d, retry_q;
  logic                   irq_d, irq_q;
  logic                   resync_d, resync_q;
  logic                   dbg_d, dbg_q;
  logic                   gate_d, gate_q;
  logic                   fault_d, fault_q;

  logic clean_tc, tout_tc;

  // Clean window: terminal count sits one below CLEAN_CYCLES so the retry
  // counter clears on the very edge that completes the error-free window.
  dmr_sat_counter #(
    .MAX (CLEAN_CYCLES - 1),
    .W   (CLEAN_W)
  ) u_clean_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  ((state_q != LOCKSTEP) || dmr.error_i),
    .en_i   (state_q == LOCKSTEP),
    .tc_o   (clean_tc)
  );

  // Halt timeout: count equals k in the k-th cycle after HALT entry, so the
  // FAULT transition lands HALT_TIMEOUT+1 cycles after entry.
  dmr_sat_counter #(
    .MAX (HALT_TIMEOUT),
    .W   (TOUT_W)
  ) u_tout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q != HALT),
    .en_i   (state_q == HALT),
    .tc_o   (tout_tc)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    irq_d    = 1'b0;
    resync_d = 1'b0;
    unique case (state_q)
      OFF: begin
        if (dmr.enable_i) state_d = LOCKSTEP;
      end
      LOCKSTEP: begin
        // A mismatch outranks a simultaneous disable: recovery must start.
        if (dmr.error_i) begin
          irq_d = 1'b1;
          if (retry_q >= MAX_RETRY_V) begin
            state_d = FAULT;
          end else begin
            state_d = HALT;
            retry_d = retry_q + 1'b1;
          end
        end else begin
          if (clean_tc) retry_d = '0;
          if (!dmr.enable_i) state_d = OFF;
        end
      end
      HALT: begin
        // Halt completion wins over a timeout expiring in the same cycle.
        if (&dmr.halted_i) begin
          state_d  = RESYNC;
          resync_d = 1'b1;
        end else if (tout_tc) begin
          state_d = FAULT;
        end
      end
      RESYNC: begin
        if (dmr.resync_done_i) state_d = LOCKSTEP;
      end
      FAULT: begin
        if (dmr.clear_i) begin
          state_d = OFF;
          retry_d = '0;
        end
      end
      default: state_d = OFF;
    endcase

    // Halt request is held through the restart pulse cycle so the harts see
    // the restart while still parked, then drops.
    dbg_d   = (state_d == HALT) || (state_d == FAULT) || resync_d;
    gate_d  = (state_d == HALT) || (state_d == RESYNC) || (state_d == FAULT);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= OFF;
      retry_q  <= '0;
      irq_q    <= 1'b0;
      resync_q <= 1'b0;
      dbg_q    <= 1'b0;
      gate_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      irq_q    <= irq_d;
      resync_q <= resync_d;
      dbg_q    <= dbg_d;
      gate_q   <= gate_d;
      fault_q  <= fault_d;
    end
  end

  assign dmr.debug_req_o = {NHARTS{dbg_q}};
  assign dmr.resync_o    = resync_q;
  assign dmr.bus_gate_o  = gate_q;
  assign dmr.error_irq_o = irq_q;
  assign dmr.fault_o     = fault_q;
  assign dmr.retry_cnt_o = retry_q;
  assign dmr.state_o     = state_q;

endmodule

// File: tb/tb_dmr_recovery_ctrl.sv
module tb_dmr_recovery_ctrl;
  import eros_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  dmr_recovery_ctrl_if #(.NHARTS(2)) dmr ();

  dmr_recovery_ctrl #(
    .NHARTS       (2),
    .MAX_RETRIES  (3),
    .HALT_TIMEOUT (255),
    .CLEAN_CYCLES (1024)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dmr    (dmr)
  );

  int checks   = 0;
  int failures = 0;

  // expected {error_irq, debug_req[1:0], resync, bus_gate} per cycle
  logic [4:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // {irq, dbg[1:0], resync, gate, fault, retry[3:0]}
  function automatic logic [9:0] outs();
    return {dmr.error_irq_o, dmr.debug_req_o, dmr.resync_o, dmr.bus_gate_o,
            dmr.fault_o, dmr.retry_cnt_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From a LOCKSTEP cycle: halt (1 cycle), restart, back to LOCKSTEP cycle 0.
  task automatic recover();
    dmr.error_i = 1'b1;
    tick();
    dmr.error_i  = 1'b0;
    dmr.halted_i = 2'b11;
    tick();
    dmr.halted_i      = 2'b00;
    dmr.resync_done_i = 1'b1;
    tick();
    dmr.resync_done_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    logic [4:0] e;
    dmr.enable_i      = 1'b0;
    dmr.error_i       = 1'b0;
    dmr.halted_i      = 2'b00;
    dmr.resync_done_i = 1'b0;
    dmr.clear_i       = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_state", 32'(dmr.state_o), 32'(OFF));
    rst_ni = 1'b1;
    tick();
    chk("off_idle", 32'(dmr.state_o), 32'(OFF));
    dmr.enable_i = 1'b1;
    tick();
    chk("enable_lockstep", 32'(dmr.state_o), 32'(LOCKSTEP));

    // 2000 clean cycles
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (dmr.state_o != LOCKSTEP || outs() != 10'd0) bad++;
    end
    chk("clean_2000_bad", 32'(bad), 32'd0);

    // Directed recovery: error at N, halted at N+3, resync_done at N+10
    exp_q.push_back(5'b11101);
    exp_q.push_back(5'b01101);
    exp_q.push_back(5'b01101);
    exp_q.push_back(5'b01111);
    for (int k = 5; k <= 10; k++) exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00000);
    dmr.error_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      dmr.error_i       = 1'b0;
      dmr.halted_i      = (k == 3) ? 2'b11 : 2'b00;
      dmr.resync_done_i = (k == 10);
      e = exp_q.pop_front();
      chk($sformatf("rec_n+%0d", k),
          32'({dmr.error_irq_o, dmr.debug_req_o, dmr.resync_o, dmr.bus_gate_o}), 32'(e));
    end
    chk("rec_state", 32'(dmr.state_o), 32'(LOCKSTEP));
    chk("rec_retry", 32'(dmr.retry_cnt_o), 32'd1);

    // Clean window: at LOCKSTEP cycle 1023 retry still 1, at 1024 it is 0
    ticks(1023);
    chk("clean_1023_retry", 32'(dmr.retry_cnt_o), 32'd1);
    tick();
    chk("clean_1024_retry", 32'(dmr.retry_cnt_o), 32'd0);

    // Error at clean cycle 1023 keeps counting
    recover();
    chk("win_retry1", 32'(dmr.retry_cnt_o), 32'd1);
    ticks(1023);
    dmr.error_i = 1'b1;
    tick();
    dmr.error_i = 1'b0;
    chk("win_1023_retry", 32'(dmr.retry_cnt_o), 32'd2);
    chk("win_1023_state", 32'(dmr.state_o), 32'(HALT));
    dmr.halted_i = 2'b11;
    tick();
    dmr.halted_i      = 2'b00;
    dmr.resync_done_i = 1'b1;
    tick();
    dmr.resync_done_i = 1'b0;

    // Async reset while in RESYNC
    dmr.error_i = 1'b1;
    tick();
    dmr.error_i = 1'b0;
    chk("pre_rst_retry", 32'(dmr.retry_cnt_o), 32'd3);
    dmr.halted_i = 2'b11;
    tick();
    dmr.halted_i = 2'b00;
    tick();
    chk("pre_rst_state", 32'(dmr.state_o), 32'(RESYNC));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'd0);
    chk("async_rst_state", 32'(dmr.state_o), 32'(OFF));
    dmr.enable_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    dmr.error_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dmr.state_o != OFF || outs() != 10'd0) bad++;
    end
    chk("off_ignores_error", 32'(bad), 32'd0);
    dmr.error_i  = 1'b0;
    dmr.enable_i = 1'b1;
    tick();
    chk("reenable_state", 32'(dmr.state_o), 32'(LOCKSTEP));
    chk("reenable_retry", 32'(dmr.retry_cnt_o), 32'd0);

    // Four errors 50 cycles apart -> fourth goes to FAULT
    for (int i = 1; i <= 3; i++) begin
      recover();
      chk($sformatf("retry_%0d", i), 32'(dmr.retry_cnt_o), 32'(i));
      ticks(50);
    end
    dmr.error_i = 1'b1;
    tick();
    chk("fault_state", 32'(dmr.state_o), 32'(FAULT));
    chk("fault_outs", 32'(outs()), 32'(10'b1_11_0_1_1_0011));
    dmr.halted_i = 2'b11;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dmr.state_o != FAULT || outs() != 10'b0_11_0_1_1_0011) bad++;
    end
    chk("fault_sticky", 32'(bad), 32'd0);
    dmr.halted_i = 2'b00;
    dmr.clear_i  = 1'b1;  // error_i and enable_i still high: clear wins
    tick();
    dmr.clear_i = 1'b0;
    dmr.error_i = 1'b0;
    chk("clear_state", 32'(dmr.state_o), 32'(OFF));
    chk("clear_outs", 32'(outs()), 32'd0);
    tick();
    chk("clear_relock", 32'(dmr.state_o), 32'(LOCKSTEP));

    // Halt timeout with only one hart halted
    dmr.error_i = 1'b1;
    tick();
    dmr.error_i  = 1'b0;
    dmr.halted_i = 2'b01;
    ticks(254);
    tick();
    chk("tout_h255_state", 32'(dmr.state_o), 32'(HALT));
    tick();
    chk("tout_h256_state", 32'(dmr.state_o), 32'(FAULT));
    chk("tout_fault", 32'(dmr.fault_o), 32'd1);
    dmr.halted_i = 2'b00;
    dmr.clear_i  = 1'b1;
    tick();
    dmr.clear_i = 1'b0;
    tick();

    // Halt arriving on the timeout cycle wins
    dmr.error_i = 1'b1;
    tick();
    dmr.error_i = 1'b0;
    ticks(254);
    tick();
    dmr.halted_i = 2'b11;
    chk("race_h255_state", 32'(dmr.state_o), 32'(HALT));
    tick();
    dmr.halted_i = 2'b00;
    chk("race_state", 32'(dmr.state_o), 32'(RESYNC));
    chk("race_resync", 32'(dmr.resync_o), 32'd1);
    dmr.resync_done_i = 1'b1;
    tick();
    dmr.resync_done_i = 1'b0;
    chk("race_lock_outs", 32'(outs()), 32'd1);

    // Disable keeps retry_cnt
    dmr.enable_i = 1'b0;
    tick();
    chk("disable_state", 32'(dmr.state_o), 32'(OFF));
    chk("disable_outs", 32'(outs()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
